// File: rtl/my_sys_mm_slave_mem.sv
// Avalon-MM slave backed by a 2^MEM_ADDR_W x 32 word RAM: write bursts, fixed-latency read bursts, sticky protocol-error flag.
// Optional macro MY_SYS_MM_SLAVE_RANDOM_WAIT_EN adds LFSR-driven random waitrequest stalls in IDLE and WR_BURST.
module my_sys_mm_slave_mem #(
    parameter int MEM_ADDR_W   = 10,
    parameter int READ_LATENCY = 2,
    parameter int BURSTCOUNT_W = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [31:0]             avs_address,
    input  logic [BURSTCOUNT_W-1:0] avs_burstcount,
    input  logic                    avs_read,
    input  logic                    avs_write,
    input  logic [3:0]              avs_byteenable,
    input  logic [31:0]             avs_writedata,
    output logic [31:0]             avs_readdata,
    output logic                    avs_readdatavalid,
    output logic                    avs_waitrequest,
    output logic                    protocol_err
);

    localparam int DEPTH = 1 << MEM_ADDR_W;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

    state_t                  state;
    logic                    ready_q;
    logic [MEM_ADDR_W-1:0]   cur_addr;
    logic [BURSTCOUNT_W-1:0] remaining;
    logic [31:0]             mem [DEPTH];

    logic [READ_LATENCY-1:0] vld_p;
    logic [31:0]             dat_p [READ_LATENCY];

    logic                    rd_pipe_busy;
    logic                    rand_wait;
    logic                    accept;
    logic                    wr_fire;
    logic                    rd_issue;
    logic [MEM_ADDR_W-1:0]   cmd_word;
    logic [MEM_ADDR_W-1:0]   wr_addr;
    logic [BURSTCOUNT_W-1:0] bc_eff;
    logic                    unused_addr_bits;

    assign cmd_word         = avs_address[MEM_ADDR_W+1:2];
    assign unused_addr_bits = ^{avs_address[31:MEM_ADDR_W+2], avs_address[1:0]};
    assign bc_eff           = (avs_burstcount == '0) ? BURSTCOUNT_W'(1) : avs_burstcount;

`ifdef MY_SYS_MM_SLAVE_RANDOM_WAIT_EN
    logic [15:0] lfsr;

    // x^16+x^14+x^13+x^11+1 Fibonacci LFSR, free-running
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign rand_wait = (lfsr[1:0] == 2'b00) && (state != RD_BURST);
`else
    assign rand_wait = 1'b0;
`endif

    assign rd_pipe_busy    = |vld_p;
    assign avs_waitrequest = !ready_q | (state == RD_BURST) | rd_pipe_busy | rand_wait;
    assign accept          = !avs_waitrequest;
    assign wr_fire         = accept && avs_write && (state != RD_BURST);
    assign wr_addr         = (state == IDLE) ? cmd_word : cur_addr;
    assign rd_issue        = (state == RD_BURST);

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (avs_byteenable[b]) begin
                    mem[wr_addr][8*b +: 8] <= avs_writedata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ready_q      <= 1'b0;
            cur_addr     <= '0;
            remaining    <= '0;
            protocol_err <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept && avs_write) begin
                        cur_addr  <= cmd_word + 1'b1;
                        remaining <= bc_eff - 1'b1;
                        if (bc_eff != BURSTCOUNT_W'(1)) begin
                            state <= WR_BURST;
                        end
                        if (avs_read) begin
                            protocol_err <= 1'b1;
                        end
                    end else if (accept && avs_read) begin
                        cur_addr  <= cmd_word;
                        remaining <= bc_eff;
                        state     <= RD_BURST;
                    end
                end
                WR_BURST: begin
                    if (avs_read) begin
                        protocol_err <= 1'b1;
                    end
                    if (wr_fire) begin
                        cur_addr  <= cur_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == BURSTCOUNT_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                RD_BURST: begin
                    cur_addr  <= cur_addr + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == BURSTCOUNT_W'(1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read pipeline: stage 0 captures the RAM word at issue, last stage drives the bus.
    // Data stages only advance with a valid beat so readdata holds between bursts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_p[i] <= '0;
            end
        end else begin
            vld_p[0] <= rd_issue;
            if (rd_issue) begin
                dat_p[0] <= mem[cur_addr];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                if (vld_p[i-1]) begin
                    dat_p[i] <= dat_p[i-1];
                end
            end
        end
    end

    assign avs_readdatavalid = vld_p[READ_LATENCY-1];
    assign avs_readdata      = dat_p[READ_LATENCY-1];

endmodule

// File: tb/tb_my_sys_mm_slave_mem.sv
// Self-checking bench for my_sys_mm_slave_mem: directed protocol scenarios plus random bursts against a word-array model.
module tb_my_sys_mm_slave_mem;

    localparam int AW  = 10;
    localparam int LAT = 2;
    localparam int BW  = 4;
    localparam int NW  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [31:0]   avs_address;
    logic [BW-1:0] avs_burstcount;
    logic          avs_read;
    logic          avs_write;
    logic [3:0]    avs_byteenable;
    logic [31:0]   avs_writedata;
    logic [31:0]   avs_readdata;
    logic          avs_readdatavalid;
    logic          avs_waitrequest;
    logic          protocol_err;

    logic [31:0] ref_mem [NW];
    bit          known   [NW];
    logic [31:0] wq [$];
    int total = 0;
    int bad   = 0;

    my_sys_mm_slave_mem #(.MEM_ADDR_W(AW), .READ_LATENCY(LAT), .BURSTCOUNT_W(BW)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .avs_address       (avs_address),
        .avs_burstcount    (avs_burstcount),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_byteenable    (avs_byteenable),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .avs_waitrequest   (avs_waitrequest),
        .protocol_err      (protocol_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (avs_waitrequest === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk({tag, " wait_bound"}, 32'(avs_waitrequest), 32'h0);
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'(a[AW+1:2]);
    endfunction

    // Writes wq[0..n-1] starting at addr; optional write=0 gap after beat index gap.
    task automatic do_write(input logic [31:0] addr, input int bc, input logic [3:0] be,
                            input int gap, input bit rd_too);
        int n = (bc == 0) ? 1 : bc;
        int w = word_of(addr);
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            avs_write      = 1'b1;
            avs_read       = rd_too && (b == 0);
            avs_writedata  = wq[b];
            avs_byteenable = be;
            avs_address    = (b == 0) ? addr : $urandom;
            avs_burstcount = (b == 0) ? BW'(bc) : BW'($urandom);
            wait_ready("wr");
            for (int k = 0; k < 4; k++)
                if (be[k]) ref_mem[w][8*k +: 8] = wq[b][8*k +: 8];
            if (be == 4'hF) known[w] = 1'b1;
            w = (w + 1) % NW;
            if (b == gap) begin
                @(negedge clk);
                avs_write = 1'b0;
                avs_read  = 1'b0;
            end
        end
        @(negedge clk);
        avs_write = 1'b0;
        avs_read  = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int bc, input string tag);
        int n = (bc == 0) ? 1 : bc;
        int w = word_of(addr);
        bit ev;
        @(negedge clk);
        avs_read       = 1'b1;
        avs_write      = 1'b0;
        avs_address    = addr;
        avs_burstcount = BW'(bc);
        wait_ready(tag);
        @(negedge clk);
        avs_read    = 1'b0;
        avs_address = $urandom;
        for (int k = 0; k <= LAT + n; k++) begin
            ev = (k >= LAT) && (k < LAT + n);
            chk({tag, " vld"}, 32'(avs_readdatavalid), 32'(ev));
            chk({tag, " waitreq"}, 32'(avs_waitrequest), 32'(k < LAT + n));
            if (ev) begin
                if (known[w]) chk({tag, " data"}, avs_readdata, ref_mem[w]);
                w = (w + 1) % NW;
            end
            if (k < LAT + n) @(negedge clk);
        end
    endtask

    initial begin
        int wrd;
        logic [31:0] ra;
        reset_n = 1'b0;
        avs_address = '0; avs_burstcount = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_byteenable = '0; avs_writedata = '0;
        #1;
        chk("rst vld", 32'(avs_readdatavalid), 32'h0);
        chk("rst rdata", avs_readdata, 32'h0);
        chk("rst waitreq", 32'(avs_waitrequest), 32'h1);
        chk("rst perr", 32'(protocol_err), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1 chk("post-rst waitreq", 32'(avs_waitrequest), 32'h1);
        @(negedge clk);
        chk("ready waitreq", 32'(avs_waitrequest), 32'h0);

        wq = '{32'hDEADBEEF};
        do_write(32'h10, 1, 4'hF, -1, 1'b0);
        do_read(32'h10, 1, "single");

        wq = '{32'd1, 32'd2, 32'd3, 32'd4};
        do_write(32'h100, 4, 4'hF, 1, 1'b0);
        do_read(32'h100, 4, "burst4");

        wq = '{32'hFFFFFFFF};
        do_write(32'h40, 1, 4'hF, -1, 1'b0);
        wq = '{32'h00000000};
        do_write(32'h40, 1, 4'h5, -1, 1'b0);
        do_read(32'h40, 1, "byteen");

        wq = '{32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003};
        do_write(32'hFFC, 3, 4'hF, -1, 1'b0);
        do_read(32'hFFC, 3, "wrap");
        do_read(32'h0, 2, "wrap-lo");
        chk("perr clean", 32'(protocol_err), 32'h0);

        for (int i = 0; i < 24; i++) begin
            ra = ($urandom & ~32'h0000_0FFC) | (32'($urandom_range(0, 31)) << 2);
            if ($urandom_range(0, 1) == 0) begin
                wq.delete();
                for (int b = 0; b < 16; b++) wq.push_back($urandom);
                do_write(ra, $urandom_range(0, 15), 4'($urandom), $urandom_range(0, 20) - 5, 1'b0);
            end else begin
                do_read(ra, $urandom_range(0, 15), "rand");
            end
        end
        chk("perr rand", 32'(protocol_err), 32'h0);

        wq = '{32'h1234_5678};
        do_write(32'h80, 1, 4'hF, -1, 1'b1);
        for (int k = 0; k < LAT + 3; k++) begin
            chk("rdwr no vld", 32'(avs_readdatavalid), 32'h0);
            @(negedge clk);
        end
        chk("rdwr perr", 32'(protocol_err), 32'h1);
        do_read(32'h80, 1, "rdwr data");
        chk("perr sticky", 32'(protocol_err), 32'h1);

        wq.delete();
        for (int b = 0; b < 8; b++) wq.push_back($urandom);
        do_write(32'h200, 8, 4'hF, -1, 1'b0);
        wrd = word_of(32'h200);
        @(negedge clk);
        avs_read = 1'b1; avs_address = 32'h200; avs_burstcount = BW'(8);
        wait_ready("rstmid");
        @(negedge clk);
        avs_read = 1'b0;
        repeat (LAT) @(negedge clk);
        chk("rstmid b1 vld", 32'(avs_readdatavalid), 32'h1);
        chk("rstmid b1 data", avs_readdata, ref_mem[wrd]);
        @(negedge clk);
        chk("rstmid b2 vld", 32'(avs_readdatavalid), 32'h1);
        chk("rstmid b2 data", avs_readdata, ref_mem[wrd+1]);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid vld", 32'(avs_readdatavalid), 32'h0);
        chk("rstmid waitreq", 32'(avs_waitrequest), 32'h1);
        chk("rstmid perr", 32'(protocol_err), 32'h0);
        chk("rstmid rdata", avs_readdata, 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("in-rst vld", 32'(avs_readdatavalid), 32'h0);
            chk("in-rst waitreq", 32'(avs_waitrequest), 32'h1);
        end
        reset_n = 1'b1;
        #1 chk("release waitreq", 32'(avs_waitrequest), 32'h1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("after-rst vld", 32'(avs_readdatavalid), 32'h0);
            chk("after-rst waitreq", 32'(avs_waitrequest), 32'h0);
        end
        do_read(32'h200, 8, "intact");
        do_read(32'h100, 4, "intact2");
        chk("perr end", 32'(protocol_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/my_sys_mm_slave_mem.md
Name: my_sys_mm_slave_mem

Overview:
- Synthesizable Avalon-MM slave (agent) backed by on-chip word RAM.
- It is the responder end of the system's Avalon-MM master interface: 32-bit address and data, byteenable, burstcount, waitrequest and pipelined readdatavalid.
- Used as the simulation/test target behind the interconnect, and as a small scratch memory in the system.
- Supports write bursts, fixed-latency read bursts and protocol-error flagging.

Parameters:
- MEM_ADDR_W, 10: word-address width; memory depth = 2^MEM_ADDR_W words of 32 bits.
- READ_LATENCY, 2: cycles from read-command acceptance to first readdatavalid; legal range 1..8.
- BURSTCOUNT_W, 4: burstcount width; max burst = 2^BURSTCOUNT_W - 1 beats.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- avs_address  in  32  byte address; word index = avs_address[MEM_ADDR_W+1:2]; other bits ignored.
- avs_burstcount  in  BURSTCOUNT_W  beats in burst; 0 is treated as 1.
- avs_read  in  1  read request.
- avs_write  in  1  write request.
- avs_byteenable  in  4  per-byte write enable.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, valid with readdatavalid.
- avs_readdatavalid  out  1  read beat valid.
- avs_waitrequest  out  1  slave not ready; the command or beat is held by the master.
- protocol_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, ready_q=0, read pipeline flushed, all outputs 0 except avs_waitrequest=1. RAM contents are not cleared. ready_q sets on the first clk edge after reset_n rises.
- avs_waitrequest = !ready_q | (state==RD_BURST) | rd_pipe_busy. It is combinational from registers only, never from inputs.
- States: IDLE, WR_BURST, RD_BURST.
- IDLE:
  - write && !waitrequest: write beat 0 at the addressed word (byte lanes per byteenable). Latch next address and remaining = burstcount-1. Go to WR_BURST if remaining > 0, else stay in IDLE.
  - read && !waitrequest: latch word address and count. Go to RD_BURST.
- WR_BURST:
  - waitrequest=0.
  - Each cycle with write=1 is a beat: write the word, increment the address, decrement remaining. Return to IDLE after the last beat.
  - write=0 cycles are idle gaps; the burst is held.
  - address and burstcount are ignored after the first beat.
  - read=1 in this state: ignored, protocol_err set.
- RD_BURST:
  - Issue one RAM read per cycle into a READ_LATENCY-deep valid/data shift pipeline, one beat per cycle, address incrementing.
  - Go to IDLE after the last issue.
  - The first readdatavalid occurs exactly READ_LATENCY cycles after the acceptance edge. All beats are back-to-back, with no gaps.
- rd_pipe_busy holds waitrequest high until the last beat of a read burst leaves the pipeline. At most one read burst is outstanding.
- Address wrap: the word address increments modulo 2^MEM_ADDR_W.
- read && write together in IDLE: the write is serviced, the read is dropped, protocol_err is set.
- protocol_err clears only on reset.
- Reset mid-burst: burst abandoned, pipeline flushed, no further readdatavalid. Writes already performed remain in RAM.
- Read-during-write to the same word is not possible; the states are exclusive.
- avs_readdata holds its last value when readdatavalid=0.

Optional Feature:
- Macro MY_SYS_MM_SLAVE_RANDOM_WAIT_EN.
- When defined: a 16-bit LFSR (seed 0xACE1 on reset, polynomial x^16+x^14+x^13+x^11+1) advances every clk. When LFSR[1:0]==2'b00, avs_waitrequest is additionally forced high in IDLE and WR_BURST, stalling command and beat acceptance. Data, latency after acceptance and ordering are unchanged.
- When undefined: no LFSR logic; waitrequest exactly as above.

Test Plan:
- Reset, then single write addr 0x10, data 0xDEADBEEF, be 0xF; single read 0x10 -> readdatavalid exactly 2 cycles after acceptance, readdata 0xDEADBEEF, waitrequest=1 until the beat is delivered.
- Write burst of 4 at 0x100 with data 1,2,3,4 and one write=0 gap after beat 2; read burst of 4 -> 4 back-to-back valid beats 1,2,3,4.
- Write 0xFFFFFFFF, then write 0x00000000 with be=0x5 to the same word; read -> 0xFF00FF00.
- Burst of 3 starting at word 1023 (byte 0xFFC) -> beats land in words 1023, 0, 1; readback confirms the wrap.
- Assert read and write together in IDLE -> write performed, no readdatavalid, protocol_err=1 and stays 1 until reset.
- Drop reset_n during beat 2 of a read burst of 8 -> readdatavalid=0 immediately and no further beats; waitrequest=1 until one clk after release; RAM contents intact on later reads.
